ex_sequencer: RTL and testbench
===============================

// Module: ex_sequencer
// PURPOSE
//  Control sequencer for the execution stage. Accepts one decoded op per handshake from decode.
//  Drives the ex-stage control inputs: sign-ext mux sel, immediate mux select, ALU control and set_cond.
//  Sequences multi-cycle MUL ops, stalls decode on downstream backpressure, and issues a flush after a taken branch.
// PARAMETERS
//  MUL_CYCLES    4   cycles an accepted MUL occupies the ALU before ex_valid (legal range 2..15)
//  FLUSH_CYCLES  2   cycles flush is held high after a taken branch (legal range 1..7)
// PORTS
//  clk           in   1  clock; all state updates on rising edge
//  rst           in   1  synchronous, active-high reset
//  id_valid      in   1  decode presents an op
//  id_ready      out  1  sequencer accepts the op this cycle
//  id_opclass    in   3  0=ALU_REG 1=ALU_IMM 2=LDST 3=BRANCH 4=MUL 5=NOP, 6/7 treated as NOP
//  id_alu_op     in   4  ALU control code from decode
//  id_set_cond   in   1  op updates the condition reserve
//  id_rd         in   6  destination register
//  alu_branch    in   1  ALU branch-taken result, sampled while a BRANCH is in ex
//  mem_ready     in   1  mem stage accepts the ex result this cycle
//  ex_imm_sel    out  1  sign-ext mux sel: 1=ls_imm, 0=alu_imm
//  ex_src_sel    out  1  immediate mux select: 1=immediate, 0=dataB
//  ex_alu_ctrl   out  4  ALU control
//  ex_set_cond   out  1  condition-reserve update enable, qualified by ex_valid
//  ex_rd         out  6  destination register of the op in ex
//  ex_valid      out  1  ex result valid for mem stage
//  flush         out  1  kill younger ops in IF/ID
//  mul_busy      out  1  MUL in progress
// BEHAVIOUR
//  - Reset: state=RUN, every output 0 (id_ready=0 during reset), mul counter=0, flush counter=0. rst beats all other inputs.
//  - Accept = id_valid & id_ready.
//  - id_ready = (state==RUN) & ~(ex_valid & ~mem_ready).
//  - Latency: controls, ex_rd and ex_valid are registered, so they are valid the cycle after accept.
//  - Decode of control fields:
//      ALU_REG: src=0, alu=id_alu_op
//      ALU_IMM: src=1, alu=id_alu_op
//      LDST: imm_sel=1, src=1, alu=4'h0 (ADD)
//      BRANCH: src=0, alu=id_alu_op
//      MUL: src=0, alu=4'hF
//      imm_sel=0 except for LDST.
//  - NOP accept: ex_valid=0 next cycle; control outputs are cleared to 0.
//  - Hold: while ex_valid & ~mem_ready, all ex_* outputs are frozen and no new op is accepted.
//  - ex_valid drops the cycle after (ex_valid & mem_ready) unless a new op is accepted in that same cycle (back-to-back, full throughput).
//  - ex_set_cond = registered id_set_cond; forced to 0 whenever ex_valid=0.
//  - States:
//      RUN   normal issue.
//      MUL   entered on a MUL accept. Loads cnt=MUL_CYCLES-1; mul_busy=1, id_ready=0, ex_valid=0, controls held.
//            cnt decrements each cycle. When cnt==0: ex_valid=1 next cycle, mul_busy=0, return to RUN.
//      FLUSH entered when ex_valid & BRANCH & alu_branch & mem_ready. flush=1 for exactly FLUSH_CYCLES cycles,
//            starting the next cycle. id_ready=0 throughout; id_valid is ignored. Then return to RUN.
//  - A not-taken BRANCH completes like an ALU op; no flush.
//  - A branch held by ~mem_ready does not flush until the cycle it is accepted.
//    alu_branch is sampled in the accept cycle only.
//  - rst asserted mid-MUL or mid-FLUSH aborts immediately: the next cycle shows reset values and no residual flush or ex_valid.
// TESTING
//  - Reset: rst=1 for 2 cycles, with id_valid=1 -> all outputs 0, id_ready=0.
//    After rst drops: id_ready=1 next cycle.
//  - Back-to-back ALU_IMM, ALU_REG, LDST with mem_ready=1:
//    -> ex_valid=1 for 3 consecutive cycles, each one cycle after its accept.
//    -> src = 1, 0, 1; imm_sel = 0, 0, 1; alu = op, op, 4'h0.
//  - MUL with MUL_CYCLES=4:
//    -> id_ready=0 and mul_busy=1 for 4 cycles; ex_valid=1 in cycle 5 after accept with alu=4'hF.
//    -> the next op is accepted once in RUN.
//  - Taken BRANCH (alu_branch=1, mem_ready=1):
//    -> flush=1 for exactly 2 cycles; id_ready=0 throughout; id_valid during the flush produces no ex_valid.
//  - Backpressure: ex_valid=1 with mem_ready=0 for 3 cycles -> ex_* frozen, id_ready=0.
//    -> when mem_ready=1, the next op issues the following cycle.
//  - rst asserted in MUL cnt=2 -> next cycle mul_busy=0, ex_valid=0, state RUN, id_ready=0 until rst drops.

Source files
------------

// File: rtl/ex_sequencer_if.sv
// Decode-to-ex handshake plus ex-stage control bundle for the execution sequencer.
// master = decode/mem side driving the sequencer, slave = the sequencer itself.
interface ex_sequencer_if;
  logic       id_valid;
  logic       id_ready;
  logic [2:0] id_opclass;
  logic [3:0] id_alu_op;
  logic       id_set_cond;
  logic [5:0] id_rd;
  logic       alu_branch;
  logic       mem_ready;
  logic       ex_imm_sel;
  logic       ex_src_sel;
  logic [3:0] ex_alu_ctrl;
  logic       ex_set_cond;
  logic [5:0] ex_rd;
  logic       ex_valid;
  logic       flush;
  logic       mul_busy;

  modport master (
    output id_valid, id_opclass, id_alu_op, id_set_cond, id_rd, alu_branch, mem_ready,
    input  id_ready, ex_imm_sel, ex_src_sel, ex_alu_ctrl, ex_set_cond, ex_rd, ex_valid,
           flush, mul_busy
  );

  modport slave (
    input  id_valid, id_opclass, id_alu_op, id_set_cond, id_rd, alu_branch, mem_ready,
    output id_ready, ex_imm_sel, ex_src_sel, ex_alu_ctrl, ex_set_cond, ex_rd, ex_valid,
           flush, mul_busy
  );
endinterface

// File: rtl/ex_sequencer.sv
// Execution-stage control sequencer: decodes ops from ID into ex controls,
// sequences multi-cycle MUL, holds on mem backpressure, flushes after a taken branch.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal issue, one op per handshake
// S_MUL   | MUL occupying the ALU, cnt counts down to completion
// S_FLUSH | flush asserted after a taken branch, cnt counts down to exit
module ex_sequencer #(
  parameter int unsigned MUL_CYCLES   = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  ex_sequencer_if.slave bus
);

  localparam logic [2:0] OP_ALU_REG = 3'd0;
  localparam logic [2:0] OP_ALU_IMM = 3'd1;
  localparam logic [2:0] OP_LDST    = 3'd2;
  localparam logic [2:0] OP_BRANCH  = 3'd3;
  localparam logic [2:0] OP_MUL     = 3'd4;
  localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_MUL = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       valid_q, valid_n;
  logic       imm_q, imm_n;
  logic       src_q, src_n;
  logic [3:0] alu_q, alu_n;
  logic       sc_q, sc_n;
  logic [5:0] rd_q, rd_n;
  logic       br_q, br_n;
  logic       id_ready_c, accept, retire, taken;

  assign id_ready_c = ~rst & (state == S_RUN) & ~(valid_q & ~bus.mem_ready);
  assign accept     = bus.id_valid & id_ready_c;
  assign retire     = valid_q & bus.mem_ready;
  // branch outcome only matters in the cycle mem takes the branch
  assign taken      = retire & br_q & bus.alu_branch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RUN;
      cnt     <= '0;
      valid_q <= 1'b0;
      imm_q   <= 1'b0;
      src_q   <= 1'b0;
      alu_q   <= '0;
      sc_q    <= 1'b0;
      rd_q    <= '0;
      br_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      valid_q <= valid_n;
      imm_q   <= imm_n;
      src_q   <= src_n;
      alu_q   <= alu_n;
      sc_q    <= sc_n;
      rd_q    <= rd_n;
      br_q    <= br_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = valid_q;
    imm_n   = imm_q;
    src_n   = src_q;
    alu_n   = alu_q;
    sc_n    = sc_q;
    rd_n    = rd_q;
    br_n    = br_q;
    case (state)
      S_RUN: begin
        if (retire) valid_n = 1'b0;
        if (taken) begin
          state_n = S_FLUSH;
          cnt_n   = FLUSH_LOAD;
        end
        if (accept) begin
          valid_n = 1'b1;
          imm_n   = 1'b0;
          src_n   = 1'b0;
          alu_n   = bus.id_alu_op;
          sc_n    = bus.id_set_cond;
          rd_n    = bus.id_rd;
          br_n    = 1'b0;
          case (bus.id_opclass)
            OP_ALU_REG: src_n = 1'b0;
            OP_ALU_IMM: src_n = 1'b1;
            OP_LDST: begin
              imm_n = 1'b1;
              src_n = 1'b1;
              alu_n = 4'h0;
            end
            OP_BRANCH: br_n = 1'b1;
            OP_MUL: begin
              alu_n   = 4'hF;
              valid_n = 1'b0;
              if (!taken) begin
                state_n = S_MUL;
                cnt_n   = MUL_LOAD;
              end
            end
            default: begin
              valid_n = 1'b0;
              alu_n   = 4'h0;
              sc_n    = 1'b0;
              rd_n    = '0;
            end
          endcase
        end
      end
      S_MUL: begin
        if (cnt == 4'd0) begin
          valid_n = 1'b1;
          state_n = S_RUN;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_FLUSH: begin
        if (retire) valid_n = 1'b0;
        if (cnt == 4'd0) state_n = S_RUN;
        else cnt_n = cnt - 4'd1;
      end
      default: state_n = S_RUN;
    endcase
  end

  assign bus.id_ready    = id_ready_c;
  assign bus.ex_valid    = valid_q;
  assign bus.ex_imm_sel  = imm_q;
  assign bus.ex_src_sel  = src_q;
  assign bus.ex_alu_ctrl = alu_q;
  assign bus.ex_set_cond = sc_q & valid_q;
  assign bus.ex_rd       = rd_q;
  assign bus.flush       = (state == S_FLUSH);
  assign bus.mul_busy    = (state == S_MUL);

endmodule

// File: tb/tb_ex_sequencer.sv
// Self-checking bench for ex_sequencer: directed scenarios plus a randomized run
// against a cycle-count reference model.
module tb_ex_sequencer;
  localparam int unsigned MUL_CYCLES   = 4;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_sequencer_if bus();
  ex_sequencer #(.MUL_CYCLES(MUL_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       imm;
    logic       src;
    logic [3:0] alu;
    logic       sc;
    logic [5:0] rd;
    logic       br;
  } ctrl_t;

  function automatic ctrl_t decode_ref(input logic [2:0] cls, input logic [3:0] alu,
                                       input logic sc, input logic [5:0] rd);
    ctrl_t c;
    c = '0;
    c.alu = alu;
    c.sc  = sc;
    c.rd  = rd;
    case (cls)
      3'd0: c.src = 1'b0;
      3'd1: c.src = 1'b1;
      3'd2: begin c.imm = 1'b1; c.src = 1'b1; c.alu = 4'h0; end
      3'd3: c.br = 1'b1;
      3'd4: c.alu = 4'hF;
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] cls, input logic [3:0] alu,
                       input logic sc, input logic [5:0] rd);
    bus.id_valid    = v;
    bus.id_opclass  = cls;
    bus.id_alu_op   = alu;
    bus.id_set_cond = sc;
    bus.id_rd       = rd;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.alu_branch = 1'b0;
    drive(1'b1, 3'd0, 4'h7, 1'b1, 6'd9);
    cyc();
    cyc();
    obs = {bus.ex_valid, bus.ex_imm_sel, bus.ex_src_sel, bus.ex_alu_ctrl, bus.ex_set_cond,
           bus.ex_rd, bus.flush, bus.mul_busy};
    checks++;
    if (obs !== 16'h0) begin errors++; $display("FAIL reset_outputs got %b want 0", obs); end
    checks++;
    if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready got %b want 0", bus.id_ready); end
    rst = 1'b0;
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    cyc();
    checks++;
    if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b want 1", bus.id_ready); end
    checks++;
    if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL valid_after_reset got %b want 0", bus.ex_valid); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] cls_t [3];
    logic       src_t [3];
    logic       imm_t [3];
    logic [3:0] alu_r, alu_e;
    logic [5:0] rd_r;
    cls_t[0] = 3'd1; cls_t[1] = 3'd0; cls_t[2] = 3'd2;
    src_t[0] = 1'b1; src_t[1] = 1'b0; src_t[2] = 1'b1;
    imm_t[0] = 1'b0; imm_t[1] = 1'b0; imm_t[2] = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_r = 4'($urandom);
      rd_r  = 6'($urandom);
      alu_e = (cls_t[i] == 3'd2) ? 4'h0 : alu_r;
      drive(1'b1, cls_t[i], alu_r, 1'b0, rd_r);
      #1;
      checks++;
      if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready op%0d got %b want 1", i, bus.id_ready); end
      cyc();
      checks++;
      if ({bus.ex_valid, bus.ex_imm_sel, bus.ex_src_sel, bus.ex_alu_ctrl, bus.ex_rd} !==
          {1'b1, imm_t[i], src_t[i], alu_e, rd_r}) begin
        errors++;
        $display("FAIL b2b_ex op%0d got v=%b imm=%b src=%b alu=%h rd=%0d want v=1 imm=%b src=%b alu=%h rd=%0d",
                 i, bus.ex_valid, bus.ex_imm_sel, bus.ex_src_sel, bus.ex_alu_ctrl, bus.ex_rd,
                 imm_t[i], src_t[i], alu_e, rd_r);
      end
    end
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    cyc();
    checks++;
    if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.ex_valid); end
  endtask

  task automatic test_mul();
    logic [3:0] next_alu;
    bus.mem_ready = 1'b1;
    drive(1'b1, 3'd4, 4'($urandom), 1'b1, 6'd5);
    cyc();
    next_alu = 4'($urandom);
    drive(1'b1, 3'd0, next_alu, 1'b0, 6'd12);
    #1;
    for (int k = 1; k <= int'(MUL_CYCLES); k++) begin
      checks++;
      if ({bus.mul_busy, bus.id_ready, bus.ex_valid} !== 3'b100) begin
        errors++;
        $display("FAIL mul_busy_cycle%0d got busy/ready/valid=%b want 100", k,
                 {bus.mul_busy, bus.id_ready, bus.ex_valid});
      end
      cyc();
    end
    checks++;
    if ({bus.ex_valid, bus.ex_alu_ctrl, bus.ex_rd, bus.ex_set_cond, bus.mul_busy, bus.id_ready} !==
        {1'b1, 4'hF, 6'd5, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mul_done got v=%b alu=%h rd=%0d sc=%b busy=%b rdy=%b want v=1 alu=f rd=5 sc=1 busy=0 rdy=1",
               bus.ex_valid, bus.ex_alu_ctrl, bus.ex_rd, bus.ex_set_cond, bus.mul_busy, bus.id_ready);
    end
    cyc();
    checks++;
    if ({bus.ex_valid, bus.ex_alu_ctrl, bus.ex_rd} !== {1'b1, next_alu, 6'd12}) begin
      errors++;
      $display("FAIL mul_next_op got v=%b alu=%h rd=%0d want v=1 alu=%h rd=12",
               bus.ex_valid, bus.ex_alu_ctrl, bus.ex_rd, next_alu);
    end
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    cyc();
  endtask

  task automatic test_branch_flush();
    logic [3:0] ba, na;
    bus.mem_ready = 1'b1;
    bus.alu_branch = 1'b0;
    ba = 4'($urandom);
    drive(1'b1, 3'd3, ba, 1'b0, 6'd7);
    cyc();
    checks++;
    if ({bus.ex_valid, bus.ex_src_sel, bus.ex_alu_ctrl} !== {1'b1, 1'b0, ba}) begin
      errors++;
      $display("FAIL branch_ex got v=%b src=%b alu=%h want v=1 src=0 alu=%h",
               bus.ex_valid, bus.ex_src_sel, bus.ex_alu_ctrl, ba);
    end
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    cyc();
    checks++;
    if ({bus.flush, bus.ex_valid} !== 2'b00) begin
      errors++; $display("FAIL not_taken got flush/valid=%b want 00", {bus.flush, bus.ex_valid});
    end
    drive(1'b1, 3'd3, 4'($urandom), 1'b0, 6'd8);
    cyc();
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    bus.alu_branch = 1'b1;
    cyc();
    bus.alu_branch = 1'b0;
    na = 4'($urandom);
    drive(1'b1, 3'd0, na, 1'b0, 6'd9);
    #1;
    for (int k = 1; k <= int'(FLUSH_CYCLES); k++) begin
      checks++;
      if ({bus.flush, bus.id_ready, bus.ex_valid} !== 3'b100) begin
        errors++;
        $display("FAIL flush_cycle%0d got flush/ready/valid=%b want 100", k,
                 {bus.flush, bus.id_ready, bus.ex_valid});
      end
      cyc();
    end
    checks++;
    if ({bus.flush, bus.id_ready, bus.ex_valid} !== 3'b010) begin
      errors++;
      $display("FAIL flush_end got flush/ready/valid=%b want 010", {bus.flush, bus.id_ready, bus.ex_valid});
    end
    cyc();
    checks++;
    if ({bus.ex_valid, bus.ex_alu_ctrl} !== {1'b1, na}) begin
      errors++;
      $display("FAIL post_flush_issue got v=%b alu=%h want v=1 alu=%h", bus.ex_valid, bus.ex_alu_ctrl, na);
    end
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    cyc();
  endtask

  task automatic test_backpressure();
    logic [3:0] a;
    logic [13:0] want;
    a = 4'($urandom);
    bus.mem_ready = 1'b1;
    drive(1'b1, 3'd1, a, 1'b1, 6'd20);
    cyc();
    bus.mem_ready = 1'b0;
    drive(1'b1, 3'd2, 4'($urandom), 1'b0, 6'd21);
    #1;
    want = {1'b1, 1'b0, 1'b1, a, 1'b1, 6'd20};
    for (int k = 0; k <= 3; k++) begin
      checks++;
      if ({bus.ex_valid, bus.ex_imm_sel, bus.ex_src_sel, bus.ex_alu_ctrl, bus.ex_set_cond, bus.ex_rd,
           bus.id_ready} !== {want, 1'b0}) begin
        errors++;
        $display("FAIL hold_cycle%0d got v=%b imm=%b src=%b alu=%h sc=%b rd=%0d rdy=%b want v=1 imm=0 src=1 alu=%h sc=1 rd=20 rdy=0",
                 k, bus.ex_valid, bus.ex_imm_sel, bus.ex_src_sel, bus.ex_alu_ctrl, bus.ex_set_cond,
                 bus.ex_rd, bus.id_ready, a);
      end
      if (k < 3) cyc();
    end
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", bus.id_ready); end
    cyc();
    checks++;
    if ({bus.ex_valid, bus.ex_imm_sel, bus.ex_src_sel, bus.ex_alu_ctrl, bus.ex_set_cond, bus.ex_rd} !==
        {1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 6'd21}) begin
      errors++;
      $display("FAIL release_issue got v=%b imm=%b src=%b alu=%h sc=%b rd=%0d want v=1 imm=1 src=1 alu=0 sc=0 rd=21",
               bus.ex_valid, bus.ex_imm_sel, bus.ex_src_sel, bus.ex_alu_ctrl, bus.ex_set_cond, bus.ex_rd);
    end
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    cyc();
    checks++;
    if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL release_drain got %b want 0", bus.ex_valid); end
  endtask

  task automatic test_reset_abort();
    bus.mem_ready = 1'b1;
    bus.alu_branch = 1'b0;
    drive(1'b1, 3'd4, 4'h3, 1'b1, 6'd30);
    cyc();
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    cyc();
    checks++;
    if (bus.mul_busy !== 1'b1) begin errors++; $display("FAIL abort_mul_pre got %b want 1", bus.mul_busy); end
    rst = 1'b1;
    drive(1'b1, 3'd0, 4'h1, 1'b0, 6'd1);
    cyc();
    checks++;
    if ({bus.mul_busy, bus.ex_valid, bus.flush, bus.id_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_mul got busy/valid/flush/ready=%b want 0000",
               {bus.mul_busy, bus.ex_valid, bus.flush, bus.id_ready});
    end
    cyc();
    rst = 1'b0;
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if ({bus.ex_valid, bus.mul_busy, bus.id_ready} !== 3'b001) begin
        errors++;
        $display("FAIL abort_mul_residual%0d got valid/busy/ready=%b want 001", k,
                 {bus.ex_valid, bus.mul_busy, bus.id_ready});
      end
    end
    drive(1'b1, 3'd3, 4'h2, 1'b0, 6'd2);
    cyc();
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    bus.alu_branch = 1'b1;
    cyc();
    bus.alu_branch = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if ({bus.flush, bus.ex_valid, bus.id_ready} !== 3'b001) begin
      errors++;
      $display("FAIL abort_flush got flush/valid/ready=%b want 001", {bus.flush, bus.ex_valid, bus.id_ready});
    end
  endtask

  task automatic test_random();
    int         mul_left, flush_left;
    logic       m_valid, running, exp_ready, v, sc, mr, ab;
    ctrl_t      m;
    logic [2:0] cls;
    logic [3:0] alu;
    logic [5:0] rd;
    rst = 1'b1;
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    cyc();
    rst = 1'b0;
    mul_left = 0;
    flush_left = 0;
    m_valid = 1'b0;
    m = '0;
    for (int n = 0; n < 600; n++) begin
      checks++;
      if (bus.ex_valid !== m_valid) begin
        errors++; $display("FAIL rand_ex_valid cyc%0d got %b want %b", n, bus.ex_valid, m_valid);
      end
      checks++;
      if ({bus.ex_imm_sel, bus.ex_src_sel, bus.ex_alu_ctrl, bus.ex_rd} !== {m.imm, m.src, m.alu, m.rd}) begin
        errors++;
        $display("FAIL rand_ctrl cyc%0d got imm=%b src=%b alu=%h rd=%0d want imm=%b src=%b alu=%h rd=%0d", n,
                 bus.ex_imm_sel, bus.ex_src_sel, bus.ex_alu_ctrl, bus.ex_rd, m.imm, m.src, m.alu, m.rd);
      end
      checks++;
      if (bus.ex_set_cond !== (m_valid & m.sc)) begin
        errors++; $display("FAIL rand_set_cond cyc%0d got %b want %b", n, bus.ex_set_cond, m_valid & m.sc);
      end
      checks++;
      if ({bus.flush, bus.mul_busy} !== {flush_left > 0, mul_left > 0}) begin
        errors++;
        $display("FAIL rand_flush_busy cyc%0d got %b%b want %b%b", n, bus.flush, bus.mul_busy,
                 flush_left > 0, mul_left > 0);
      end
      running = (mul_left == 0) && (flush_left == 0);
      v   = ($urandom_range(0, 3) != 0);
      cls = 3'($urandom_range(0, 7));
      alu = 4'($urandom);
      sc  = 1'($urandom);
      rd  = 6'($urandom);
      mr  = ($urandom_range(0, 3) != 0);
      ab  = 1'($urandom);
      // keep younger ops out of the cycle a taken branch leaves ex
      if (running && m_valid && m.br && ab && mr) v = 1'b0;
      drive(v, cls, alu, sc, rd);
      bus.mem_ready = mr;
      bus.alu_branch = ab;
      #1;
      exp_ready = running && !(m_valid && !mr);
      checks++;
      if (bus.id_ready !== exp_ready) begin
        errors++; $display("FAIL rand_id_ready cyc%0d got %b want %b", n, bus.id_ready, exp_ready);
      end
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) m_valid = 1'b1;
      end else if (flush_left > 0) begin
        flush_left--;
        if (m_valid && mr) m_valid = 1'b0;
      end else begin
        if (m_valid && m.br && ab && mr) flush_left = int'(FLUSH_CYCLES);
        if (m_valid && mr) m_valid = 1'b0;
        if (v && exp_ready) begin
          m = decode_ref(cls, alu, sc, rd);
          if (cls == 3'd4) begin
            mul_left = int'(MUL_CYCLES);
            m_valid = 1'b0;
          end else begin
            m_valid = (cls <= 3'd3);
          end
        end
      end
      cyc();
    end
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.alu_branch = 1'b0;
    drive(1'b0, 3'd0, 4'h0, 1'b0, 6'd0);
    test_reset();
    test_back_to_back();
    test_mul();
    test_branch_flush();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
